mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, holding the architectural HI/LO registers.
//   Sits beside alu, downstream of regfile: operands come from rd1/rd2, and hi/lo are muxed into writeback for MFHI/MFLO.
//   Controller stalls the pipeline on busy. Radix-2: one product/quotient bit per clock.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-low (0 = reset)
//   start   in   1      launch op; sampled only in IDLE
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a       in   WIDTH  rs operand (multiplicand / dividend)
//   b       in   WIDTH  rt operand (multiplier / divisor)
//   hi_we   in   1      MTHI: hi <= wd
//   lo_we   in   1      MTLO: lo <= wd
//   wd      in   WIDTH  MTHI/MTLO write data
//   busy    out  1      operation in flight; controller stalls while 1
//   done    out  1      one-cycle pulse; hi/lo valid in the same cycle
//   hi      out  WIDTH  HI register (product upper / remainder)
//   lo      out  WIDTH  LO register (product lower / quotient)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, internal regs cleared.
//     Reset mid-operation aborts immediately; no partial result is written.
//   FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE:
//     start=1 at edge E0: latch op, |a|, |b| (abs value only for signed ops), result signs; counter=0; go RUN.
//   RUN: one iteration per edge E1..E_WIDTH. After E_WIDTH (counter==WIDTH-1), go FIX.
//     Multiply: shift-add on a 2*WIDTH accumulator.
//     Divide: restoring; remainder is WIDTH+1 bits.
//   FIX, edge E_{WIDTH+1}:
//     Negate for signed ops where needed, write hi/lo, go IDLE.
//   busy: 1 for cycles after E0 up to and including E_{WIDTH+1}'s preceding cycle; 0 in cycle after E_{WIDTH+1}.
//   done: 1 only in the cycle following E_{WIDTH+1}.
//   Latency: start cycle to done cycle = WIDTH+2 clocks (34 at default).
//   hi/lo hold their old values throughout RUN; updates are atomic at FIX.
//   Result rules:
//     Signed multiply: {hi,lo} = 2*WIDTH two's-complement product.
//     Signed divide: quotient truncates toward zero; remainder takes dividend's sign.
//     b==0 (DIV/DIVU): hi=a, lo=all ones; full latency, no exception.
//     DIV most-negative / -1: lo=most-negative (wraps), hi=0.
//   start while busy: ignored (no restart, no queue).
//   hi_we/lo_we while busy: ignored.
//   hi_we/lo_we in IDLE: write at the edge.
//     Same edge as start: the write takes effect; the later FIX overwrites it.
//     hi_we and lo_we together: both written with wd.
//   done and a new start in the same cycle: legal; new op accepted (state is IDLE).
//   op/a/b need be valid only in the start cycle; later changes have no effect.
// TESTING
//   1. MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly 34 clocks after start cycle.
//   2. MULT a=FFFFFFFD(-3) b=7 -> hi=FFFFFFFF lo=FFFFFFEB; MULT 80000000*80000000 -> hi=40000000 lo=0.
//   3. DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU a=100 b=7 -> lo=0000000E hi=00000002.
//   4. DIV a=12345678 b=0 -> hi=12345678 lo=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//   5. Start DIVU 100/7; pulse start (MULTU) and hi_we at iteration 5 -> ignored, result 14/2 unchanged;
//      rerun and drop reset at iteration 10 -> busy=0, hi=lo=0 immediately, no done pulse.
//   6. IDLE: hi_we=1 wd=DEADBEEF -> hi=DEADBEEF next edge, lo unchanged;
//      then lo_we=1 wd=CAFEF00D -> lo=CAFEF00D; hi/lo stable while busy until done.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the pipeline controller and the multiply/divide unit.
// The controller drives the operation request and MTHI/MTLO writes; the unit returns status and HI/LO.
`timescale 1ns/1ps
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on magnitudes and applies signs in a final FIX cycle so HI/LO update atomically.
`timescale 1ns/1ps
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    always_comb begin
        a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
        b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // The shifted partial remainder needs one extra bit before the trial subtract.
        div_shift = {rem, acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix   = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wd;
                    if (bus.lo_we) lo_r <= bus.wd;
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        operand  <= bus.op[1] ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                        rem      <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= bus.op[1] & (bus.b == '0);
                        count    <= '0;
                        busy_r   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        rem             <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, latency, busy-time
// protection, abort on reset and MTHI/MTLO writes.
`timescale 1ns/1ps
module tb_mul_div_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op from just after an edge and wait (bounded) for done; a/b are scrambled after launch.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [31:0] h, output logic [31:0] l);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 32'hA5A5_5A5A;
        bus.b     = 32'h0000_0003;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        h = bus.hi;
        l = bus.lo;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi got=%h want=00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo got=%h want=00000000", bus.lo); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multiply();
        int lat;
        logic [31:0] h, l;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l);
        checks++; if (lat !== 34) begin failures++; $display("[TB] FAIL multu_latency got=%0d want=34", lat); end
        checks++; if (h !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL multu_hi got=%h want=fffffffe", h); end
        checks++; if (l !== 32'h0000_0001) begin failures++; $display("[TB] FAIL multu_lo got=%h want=00000001", l); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_at_done got=%b want=0", bus.busy); end
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, h, l);
        checks++; if (h !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_neg_hi got=%h want=ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mult_neg_lo got=%h want=ffffffeb", l); end
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, h, l);
        checks++; if (h !== 32'h4000_0000) begin failures++; $display("[TB] FAIL mult_minmin_hi got=%h want=40000000", h); end
        checks++; if (l !== 32'h0000_0000) begin failures++; $display("[TB] FAIL mult_minmin_lo got=%h want=00000000", l); end
    endtask

    task automatic test_divide();
        int lat;
        logic [31:0] h, l;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, h, l);
        checks++; if (l !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_neg_lo got=%h want=fffffffd", l); end
        checks++; if (h !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_neg_hi got=%h want=ffffffff", h); end
        run_op(2'b11, 32'd100, 32'd7, lat, h, l);
        checks++; if (lat !== 34) begin failures++; $display("[TB] FAIL divu_latency got=%0d want=34", lat); end
        checks++; if (l !== 32'h0000_000E) begin failures++; $display("[TB] FAIL divu_lo got=%h want=0000000e", l); end
        checks++; if (h !== 32'h0000_0002) begin failures++; $display("[TB] FAIL divu_hi got=%h want=00000002", h); end
    endtask

    task automatic test_div_edge();
        int lat;
        logic [31:0] h, l;
        run_op(2'b10, 32'h1234_5678, 32'h0, lat, h, l);
        checks++; if (lat !== 34) begin failures++; $display("[TB] FAIL divzero_latency got=%0d want=34", lat); end
        checks++; if (h !== 32'h1234_5678) begin failures++; $display("[TB] FAIL divzero_hi got=%h want=12345678", h); end
        checks++; if (l !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divzero_lo got=%h want=ffffffff", l); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l);
        checks++; if (l !== 32'h8000_0000) begin failures++; $display("[TB] FAIL divovf_lo got=%h want=80000000", l); end
        checks++; if (h !== 32'h0000_0000) begin failures++; $display("[TB] FAIL divovf_hi got=%h want=00000000", h); end
    endtask

    task automatic test_busy_ignore();
        int n;
        logic stable;
        logic saw_done;
        // hi/lo currently hold the overflow result from the previous task
        bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        stable = 1'b1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (n == 6) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
                bus.hi_we = 1'b1; bus.wd = 32'h1357_9BDF;
            end
            @(posedge clk); #1;
            bus.start = 1'b0; bus.hi_we = 1'b0;
            n++;
            if (bus.done !== 1'b1 && (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000)) stable = 1'b0;
        end
        checks++; if (n !== 34) begin failures++; $display("[TB] FAIL ignore_latency got=%0d want=34", n); end
        checks++; if (stable !== 1'b1) begin failures++; $display("[TB] FAIL ignore_hilo_hold got=%b want=1", stable); end
        checks++; if (bus.lo !== 32'h0000_000E) begin failures++; $display("[TB] FAIL ignore_lo got=%h want=0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'h0000_0002) begin failures++; $display("[TB] FAIL ignore_hi got=%h want=00000002", bus.hi); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_no_restart got=%b want=0", bus.busy); end

        bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", bus.busy); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("[TB] FAIL abort_hi got=%h want=00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("[TB] FAIL abort_lo got=%h want=00000000", bus.lo); end
        #2;
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done got=%b want=0", saw_done); end
    endtask

    task automatic test_mt_regs();
        int n;
        logic stable;
        bus.hi_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL mthi_hi got=%h want=deadbeef", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("[TB] FAIL mthi_lo got=%h want=00000000", bus.lo); end
        bus.lo_we = 1'b1; bus.wd = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        checks++; if (bus.lo !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL mtlo_lo got=%h want=cafef00d", bus.lo); end
        checks++; if (bus.hi !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL mtlo_hi got=%h want=deadbeef", bus.hi); end
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'h1111_2222;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'h1111_2222 || bus.lo !== 32'h1111_2222) begin
            failures++; $display("[TB] FAIL mt_both got=%h/%h want=11112222/11112222", bus.hi, bus.lo);
        end
        // write coincident with start lands first, then the result overwrites it
        bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.wd = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'h0BAD_F00D) begin failures++; $display("[TB] FAIL mt_with_start got=%h want=0badf00d", bus.hi); end
        n = 1;
        stable = 1'b1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'h1111_2222) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("[TB] FAIL hilo_stable got=%b want=1", stable); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0000_000F) begin
            failures++; $display("[TB] FAIL mt_overwrite got=%h/%h want=00000000/0000000f", bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] h, l;
        run_op(2'b01, 32'd6, 32'd7, lat, h, l);
        checks++; if (l !== 32'h0000_002A || h !== 32'h0) begin
            failures++; $display("[TB] FAIL b2b_first got=%h/%h want=00000000/0000002a", h, l);
        end
        run_op(2'b11, 32'd100, 32'd7, lat, h, l);
        checks++; if (lat !== 34) begin failures++; $display("[TB] FAIL b2b_latency got=%0d want=34", lat); end
        checks++; if (l !== 32'h0000_000E || h !== 32'h0000_0002) begin
            failures++; $display("[TB] FAIL b2b_second got=%h/%h want=00000002/0000000e", h, l);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wd    = '0;
        #1;
        test_reset();
        test_multiply();
        test_divide();
        test_div_edge();
        test_busy_ignore();
        test_mt_regs();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
